ddr4_v2_2_20_w_upsizer_pack: RTL and testbench

Write-data packer for the AXI upsizer W channel. It accepts narrow slave write beats and assembles them into master-width words. Each beat goes into the lane selected by a running word index. A completed wide word is pushed to the master W channel when the last lane is written, when the burst ends, or on every beat of a FIXED burst. It sits between the upsizer's address/command stage (source of start offset and length) and the DDR4 controller's AXI write-data port.

---
 rtl/ddr4_v2_2_20_w_upsizer_pack.sv | 132 +++++++++++++
 tb/tb_ddr4_v2_2_20_w_upsizer_pack.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_v2_2_20_w_upsizer_pack.sv
// AXI upsizer W-channel packer: narrow slave beats
// are assembled into master-width words by lane index.
module ddr4_v2_2_20_w_upsizer_pack #(
  parameter C_FAMILY = "virtex6",
  parameter int C_S_DATA_WIDTH = 32,
  parameter int C_M_DATA_WIDTH = 128,
  localparam int C_RATIO = C_M_DATA_WIDTH / C_S_DATA_WIDTH,
  localparam int C_RATIO_LOG = $clog2(C_RATIO)
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        CMD_VALID,
  output logic                        CMD_READY,
  input  logic [C_RATIO_LOG-1:0]      CMD_OFFSET,
  input  logic [7:0]                  CMD_LEN,
  input  logic                        CMD_FIXED,
  input  logic [C_S_DATA_WIDTH-1:0]   S_WDATA,
  input  logic [C_S_DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                        S_WLAST,
  input  logic                        S_WVALID,
  output logic                        S_WREADY,
  output logic [C_M_DATA_WIDTH-1:0]   M_WDATA,
  output logic [C_M_DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                        M_WLAST,
  output logic                        M_WVALID,
  input  logic                        M_WREADY,
  output logic                        LAST_ERR
);
  localparam int SW = C_S_DATA_WIDTH;
  localparam int SB = C_S_DATA_WIDTH / 8;
  localparam int MW = C_M_DATA_WIDTH;
  localparam int MB = C_M_DATA_WIDTH / 8;

  typedef enum logic {IDLE, DATA} state_t;

  state_t               state, state_nx;
  logic [C_RATIO_LOG-1:0] idx, idx_nx;
  logic [7:0]           cnt, cnt_nx;
  logic                 fixed, fixed_nx;
  logic [MW-1:0]        wdata, wdata_nx;
  logic [MB-1:0]        wstrb, wstrb_nx;
  logic                 mvalid, mvalid_nx;
  logic                 mlast, mlast_nx;
  logic                 err, err_nx;
  logic                 beat, take, push, last_beat;

  assign CMD_READY = ARESETN && (state == IDLE);
  assign S_WREADY  = ARESETN && (state == DATA) &&
                     (!mvalid || M_WREADY);

  assign beat      = S_WVALID && S_WREADY;
  assign take      = mvalid && M_WREADY;
  assign last_beat = (cnt == 8'd0);
  assign push      = beat && ((idx == {C_RATIO_LOG{1'b1}}) ||
                              last_beat || fixed);

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    cnt_nx    = cnt;
    fixed_nx  = fixed;
    wdata_nx  = wdata;
    wstrb_nx  = wstrb;
    mvalid_nx = mvalid;
    mlast_nx  = mlast;
    err_nx    = 1'b0;
    // a taken word frees the register; a same-cycle beat starts fresh
    if (take) begin
      mvalid_nx = 1'b0;
      wstrb_nx  = '0;
    end
    unique case (state)
      IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          state_nx = DATA;
          idx_nx   = CMD_OFFSET;
          cnt_nx   = CMD_LEN;
          fixed_nx = CMD_FIXED;
        end
      end
      DATA: begin
        if (beat) begin
          for (int i = 0; i < C_RATIO; i++) begin
            if (idx == C_RATIO_LOG'(i)) begin
              wdata_nx[i*SW +: SW] = S_WDATA;
              wstrb_nx[i*SB +: SB] = S_WSTRB;
            end
          end
          err_nx = (S_WLAST != last_beat);
          if (!fixed) idx_nx = idx + 1'b1;
          if (last_beat) state_nx = IDLE;
          else cnt_nx = cnt - 8'd1;
          if (push) begin
            mvalid_nx = 1'b1;
            mlast_nx  = last_beat;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      fixed  <= 1'b0;
      wdata  <= '0;
      wstrb  <= '0;
      mvalid <= 1'b0;
      mlast  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      fixed  <= fixed_nx;
      wdata  <= wdata_nx;
      wstrb  <= wstrb_nx;
      mvalid <= mvalid_nx;
      mlast  <= mlast_nx;
      err    <= err_nx;
    end
  end

  assign M_WDATA  = wdata;
  assign M_WSTRB  = wstrb;
  assign M_WLAST  = mlast;
  assign M_WVALID = mvalid;
  assign LAST_ERR = err;

endmodule

// File: tb/tb_ddr4_v2_2_20_w_upsizer_pack.sv
// Randomized bench for the W upsizer packer against
// a burst-level reference model of expected wide words.
module tb_ddr4_v2_2_20_w_upsizer_pack;
  localparam int SW = 32;
  localparam int MW = 128;
  localparam int R  = 4;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          ARESETN;
  logic          CMD_VALID, CMD_READY;
  logic [RL-1:0] CMD_OFFSET;
  logic [7:0]    CMD_LEN;
  logic          CMD_FIXED;
  logic [SW-1:0] S_WDATA;
  logic [3:0]    S_WSTRB;
  logic          S_WLAST, S_WVALID, S_WREADY;
  logic [MW-1:0] M_WDATA;
  logic [15:0]   M_WSTRB;
  logic          M_WLAST, M_WVALID, M_WREADY;
  logic          LAST_ERR;

  always #5 clk = ~clk;

  ddr4_v2_2_20_w_upsizer_pack #(
    .C_FAMILY("virtex6"),
    .C_S_DATA_WIDTH(SW),
    .C_M_DATA_WIDTH(MW)
  ) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OFFSET(CMD_OFFSET), .CMD_LEN(CMD_LEN),
    .CMD_FIXED(CMD_FIXED),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
    .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
    .S_WREADY(S_WREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
    .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
    .M_WREADY(M_WREADY), .LAST_ERR(LAST_ERR)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [MW-1:0] got,
                       input logic [MW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  typedef struct {
    logic [MW-1:0] d;
    logic [15:0]   s;
    logic          l;
  } word_t;

  word_t expq[$];
  logic [SW-1:0] bd[256];
  logic [3:0]    bs[256];
  bit            bl[256];
  bit            bp[256];
  bit            beat_push = 1'b0;
  int exp_err = 0, obs_err = 0;
  int exp_beats = 0, obs_beats = 0;
  int s_wait = 0;
  int rdy_mode = 0;
  int stall_cnt = 0;

  // Expected wide words for one burst, from the lane rules.
  task automatic model_burst(input int off, input int len,
                             input bit fx);
    word_t w;
    int lane;
    lane = off;
    w.d = '0;
    w.s = '0;
    w.l = 1'b0;
    for (int b = 0; b <= len; b++) begin
      w.d[lane*SW +: SW] = bd[b];
      w.s[lane*4 +: 4] = bs[b];
      bp[b] = fx || (lane == R-1) || (b == len);
      if (bl[b] != (b == len)) exp_err++;
      if (bp[b]) begin
        w.l = (b == len);
        expq.push_back(w);
        w.d = '0;
        w.s = '0;
      end
      if (!fx) lane = (lane + 1) % R;
    end
    exp_beats += len + 1;
  endtask

  task automatic fill(input int len, input int mode);
    for (int b = 0; b <= len; b++) begin
      bd[b] = (mode == 0) ? SW'(b) : SW'($urandom);
      bs[b] = (mode == 0) ? 4'hF : 4'($urandom);
      bl[b] = (b == len);
      if (mode == 1 && $urandom_range(9) == 0)
        bl[b] = !bl[b];
    end
  endtask

  task automatic run_burst(input int off, input int len,
                           input bit fx, input int gap);
    int t;
    model_burst(off, len, fx);
    @(posedge clk); #1;
    CMD_VALID  = 1'b1;
    CMD_OFFSET = RL'(off);
    CMD_LEN    = 8'(len);
    CMD_FIXED  = fx;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!CMD_READY && t < 200);
    check("cmd_ready", CMD_READY, 1);
    @(posedge clk); #1;
    CMD_VALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      while ($urandom_range(99) < gap) begin
        S_WVALID = 1'b0;
        @(posedge clk); #1;
      end
      S_WVALID  = 1'b1;
      S_WDATA   = bd[b];
      S_WSTRB   = bs[b];
      S_WLAST   = bl[b];
      beat_push = bp[b];
      t = 0;
      do begin @(negedge clk); t++; end
      while (!S_WREADY && t < 200);
      check("s_wready", S_WREADY, 1);
      @(posedge clk); #1;
    end
    S_WVALID  = 1'b0;
    beat_push = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || M_WVALID) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain", expq.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      M_WREADY = 1'($urandom_range(1));
    end else if (rdy_mode == 2 && M_WVALID && stall_cnt < 3) begin
      M_WREADY = 1'b0;
      stall_cnt++;
    end else begin
      M_WREADY = 1'b1;
    end
  end

  logic [MW-1:0] pd;
  logic [15:0]   ps;
  logic          pl;
  bit            pstall = 1'b0;
  bit            pend = 1'b0;

  always @(negedge clk) begin
    word_t w;
    logic [MW-1:0] mask;
    if (!ARESETN) begin
      pstall = 1'b0;
      pend   = 1'b0;
    end else begin
      if (pend) check("push_latency", M_WVALID, 1);
      pend = S_WVALID && S_WREADY && beat_push;
      if (S_WVALID && S_WREADY) obs_beats++;
      if (S_WVALID && !S_WREADY) s_wait++;
      if (LAST_ERR) obs_err++;
      if (M_WVALID && !M_WREADY)
        check("bp_s_wready", S_WREADY, 0);
      if (pstall) begin
        check("hold_valid", M_WVALID, 1);
        check("hold_data", M_WDATA, pd);
        check("hold_strb", M_WSTRB, ps);
        check("hold_last", M_WLAST, pl);
      end
      pstall = M_WVALID && !M_WREADY;
      pd = M_WDATA;
      ps = M_WSTRB;
      pl = M_WLAST;
      if (M_WVALID && M_WREADY) begin
        if (expq.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          w = expq.pop_front();
          for (int i = 0; i < 16; i++)
            mask[i*8 +: 8] = {8{w.s[i]}};
          check("m_wdata", M_WDATA & mask, w.d & mask);
          check("m_wstrb", M_WSTRB, w.s);
          check("m_wlast", M_WLAST, w.l);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    ARESETN = 1'b0;
    CMD_VALID = 1'b0; CMD_OFFSET = '0;
    CMD_LEN = '0; CMD_FIXED = 1'b0;
    S_WDATA = '0; S_WSTRB = '0;
    S_WLAST = 1'b0; S_WVALID = 1'b0;
    M_WREADY = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mvalid", M_WVALID, 0);
    check("rst_mdata", M_WDATA, 0);
    check("rst_mstrb", M_WSTRB, 0);
    check("rst_mlast", M_WLAST, 0);
    check("rst_lasterr", LAST_ERR, 0);
    check("rst_cmd_ready", CMD_READY, 0);
    check("rst_s_wready", S_WREADY, 0);
    @(posedge clk); #1;
    ARESETN = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", CMD_READY, 1);

    fill(7, 0);
    run_burst(0, 7, 1'b0, 0);
    drain();

    fill(2, 0);
    run_burst(2, 2, 1'b0, 0);
    drain();

    fill(3, 0);
    run_burst(1, 3, 1'b1, 0);
    drain();

    rdy_mode = 2;
    stall_cnt = 0;
    s_wait = 0;
    fill(7, 0);
    run_burst(0, 7, 1'b0, 0);
    drain();
    check("stall_cycles", s_wait, 3);
    rdy_mode = 0;

    e0 = obs_err;
    fill(3, 0);
    bl[2] = 1'b1;
    run_burst(0, 3, 1'b0, 0);
    drain();
    @(negedge clk);
    check("last_err_once", obs_err - e0, 1);

    @(posedge clk); #1;
    CMD_VALID = 1'b1; CMD_OFFSET = '0;
    CMD_LEN = 8'd3; CMD_FIXED = 1'b0;
    @(negedge clk);
    check("mid_cmd_ready", CMD_READY, 1);
    @(posedge clk); #1;
    CMD_VALID = 1'b0;
    S_WVALID = 1'b1; S_WDATA = 32'hA5A5_0001;
    S_WSTRB = 4'hF; S_WLAST = 1'b0;
    @(negedge clk);
    check("mid_beat0", S_WREADY, 1);
    @(posedge clk); #1;
    S_WDATA = 32'hA5A5_0002;
    @(negedge clk);
    check("mid_beat1", S_WREADY, 1);
    @(posedge clk); #1;
    S_WVALID = 1'b0;
    ARESETN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_mvalid", M_WVALID, 0);
    check("mid_rst_mdata", M_WDATA, 0);
    check("mid_rst_mstrb", M_WSTRB, 0);
    check("mid_rst_mlast", M_WLAST, 0);
    check("mid_rst_cmd_ready", CMD_READY, 0);
    check("mid_rst_s_wready", S_WREADY, 0);
    ARESETN = 1'b1;
    exp_beats += 2;
    @(negedge clk);
    check("mid_rel_cmd_ready", CMD_READY, 1);
    check("mid_rel_mvalid", M_WVALID, 0);
    fill(1, 0);
    run_burst(2, 1, 1'b0, 0);
    drain();

    rdy_mode = 1;
    for (int k = 0; k < 25; k++) begin
      int off, len;
      bit fx;
      off = $urandom_range(R-1);
      len = $urandom_range(19);
      fx  = ($urandom_range(3) == 0);
      fill(len, 1);
      run_burst(off, len, fx, 30);
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("last_err_total", obs_err, exp_err);
    check("beat_total", obs_beats, exp_beats);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
